// File: rtl/exe_issue_queue_pkg.sv
// rtl/exe_issue_queue_pkg.sv - shared constants and types for the EXE issue queue
package exe_issue_queue_pkg;

    localparam int IQ_DEPTH   = 8;
    localparam int IQ_TAG_W   = 6;
    localparam int IQ_INFO_W  = 170;

    // Operand slots per entry: A, B and C (store data)
    localparam int IQ_NUM_OPS = 3;
    localparam int OP_A       = 0;
    localparam int OP_B       = 1;
    localparam int OP_C       = 2;

    // Narrow control fields carried alongside each instruction
    typedef struct packed {
        logic [5:0] alu_ctrl;
        logic [4:0] shamt;
        logic [4:0] wreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
    } iq_ctrl_t;

endpackage

// File: rtl/exe_issue_queue_select.sv
// rtl/exe_issue_queue_select.sv - priority encoder picking the oldest ready entry
module iq_oldest_ready_select #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] i_ready,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top down so the lowest (oldest) ready index wins
    always_comb begin
        o_found = |i_ready;
        o_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_ready[i]) o_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/exe_issue_queue.sv
// rtl/exe_issue_queue.sv - collapsing reservation station feeding EXE operand registers
module exe_issue_queue
    import exe_issue_queue_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int TAG_W  = IQ_TAG_W,
    parameter int INFO_W = IQ_INFO_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [31:0]       disp_instr,
    input  logic [31:0]       disp_pc,
    input  logic [5:0]        disp_alu_ctrl,
    input  logic [4:0]        disp_shamt,
    input  logic [4:0]        disp_wreg,
    input  logic              disp_regwrite,
    input  logic              disp_memread,
    input  logic              disp_memwrite,
    input  logic [INFO_W-1:0] disp_info,
    input  logic              disp_a_rdy,
    input  logic [31:0]       disp_a_val,
    input  logic [TAG_W-1:0]  disp_a_tag,
    input  logic              disp_b_rdy,
    input  logic [31:0]       disp_b_val,
    input  logic [TAG_W-1:0]  disp_b_tag,
    input  logic              disp_c_rdy,
    input  logic [31:0]       disp_c_val,
    input  logic [TAG_W-1:0]  disp_c_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [31:0]       cdb_data,
    input  logic              stall,
    output logic              iss_valid,
    output logic [31:0]       iss_instr,
    output logic [31:0]       iss_pc,
    output logic [31:0]       iss_opa,
    output logic [31:0]       iss_opb,
    output logic [31:0]       iss_memwdata,
    output logic [5:0]        iss_alu_ctrl,
    output logic [4:0]        iss_shamt,
    output logic [4:0]        iss_wreg,
    output logic              iss_regwrite,
    output logic              iss_memread,
    output logic              iss_memwrite,
    output logic [INFO_W-1:0] iss_info
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Entry storage; index 0 is always the oldest
    logic [DEPTH-1:0]      r_valid;
    logic [CNT_W-1:0]      r_count;
    logic [31:0]           r_instr [DEPTH];
    logic [31:0]           r_pc    [DEPTH];
    iq_ctrl_t              r_ctrl  [DEPTH];
    logic [INFO_W-1:0]     r_info  [DEPTH];
    logic [IQ_NUM_OPS-1:0] r_rdy   [DEPTH];
    logic [31:0]           r_val   [DEPTH][IQ_NUM_OPS];
    logic [TAG_W-1:0]      r_tag   [DEPTH][IQ_NUM_OPS];

    // Operand state after this cycle's CDB compare
    logic [IQ_NUM_OPS-1:0] w_wk_rdy [DEPTH];
    logic [31:0]           w_wk_val [DEPTH][IQ_NUM_OPS];

    // Next-state view of the entry array
    logic [DEPTH-1:0]      w_n_valid;
    logic [31:0]           w_n_instr [DEPTH];
    logic [31:0]           w_n_pc    [DEPTH];
    iq_ctrl_t              w_n_ctrl  [DEPTH];
    logic [INFO_W-1:0]     w_n_info  [DEPTH];
    logic [IQ_NUM_OPS-1:0] w_n_rdy   [DEPTH];
    logic [31:0]           w_n_val   [DEPTH][IQ_NUM_OPS];
    logic [TAG_W-1:0]      w_n_tag   [DEPTH][IQ_NUM_OPS];

    logic [IQ_NUM_OPS-1:0] w_d_rdy;
    logic [31:0]           w_d_val [IQ_NUM_OPS];
    logic [TAG_W-1:0]      w_d_tag [IQ_NUM_OPS];
    iq_ctrl_t              w_d_ctrl;

    logic [DEPTH-1:0]      w_ready;
    logic                  w_found;
    logic [IDX_W-1:0]      w_sel;
    logic                  w_issue;
    logic                  w_disp;
    logic [IDX_W-1:0]      w_widx;

    assign disp_ready = (r_count != CNT_W'(DEPTH));
    assign w_issue    = !stall && w_found;
    assign w_disp     = disp_valid && disp_ready && !flush;
    assign w_widx     = IDX_W'(r_count - CNT_W'(w_issue));
    assign w_d_ctrl   = {disp_alu_ctrl, disp_shamt, disp_wreg,
                         disp_regwrite, disp_memread, disp_memwrite};

    // Gather the dispatch operands into slot-indexed form
    always_comb begin
        w_d_rdy       = {disp_c_rdy, disp_b_rdy, disp_a_rdy};
        w_d_val[OP_A] = disp_a_val;
        w_d_val[OP_B] = disp_b_val;
        w_d_val[OP_C] = disp_c_val;
        w_d_tag[OP_A] = disp_a_tag;
        w_d_tag[OP_B] = disp_b_tag;
        w_d_tag[OP_C] = disp_c_tag;
    end

    // Select looks at registered readiness only, so a CDB capture is usable next cycle
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ready[i] = r_valid[i] && (&r_rdy[i]);
        end
    end

    iq_oldest_ready_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .i_ready (w_ready),
        .o_found (w_found),
        .o_idx   (w_sel)
    );

    // CDB wake-up of every waiting operand already in the queue
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < IQ_NUM_OPS; k++) begin
                if (!r_rdy[i][k] && cdb_valid && (r_tag[i][k] == cdb_tag)) begin
                    w_wk_rdy[i][k] = 1'b1;
                    w_wk_val[i][k] = cdb_data;
                end else begin
                    w_wk_rdy[i][k] = r_rdy[i][k];
                    w_wk_val[i][k] = r_val[i][k];
                end
            end
        end
    end

    // Build the next array: woken entries, collapse above the issued slot, then append dispatch
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_n_valid[i] = r_valid[i];
            w_n_instr[i] = r_instr[i];
            w_n_pc[i]    = r_pc[i];
            w_n_ctrl[i]  = r_ctrl[i];
            w_n_info[i]  = r_info[i];
            w_n_rdy[i]   = w_wk_rdy[i];
            w_n_val[i]   = w_wk_val[i];
            w_n_tag[i]   = r_tag[i];
        end
        if (w_issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= w_sel) begin
                    w_n_valid[i] = r_valid[i+1];
                    w_n_instr[i] = r_instr[i+1];
                    w_n_pc[i]    = r_pc[i+1];
                    w_n_ctrl[i]  = r_ctrl[i+1];
                    w_n_info[i]  = r_info[i+1];
                    w_n_rdy[i]   = w_wk_rdy[i+1];
                    w_n_val[i]   = w_wk_val[i+1];
                    w_n_tag[i]   = r_tag[i+1];
                end
            end
            w_n_valid[DEPTH-1] = 1'b0;
        end
        if (w_disp) begin
            w_n_valid[w_widx] = 1'b1;
            w_n_instr[w_widx] = disp_instr;
            w_n_pc[w_widx]    = disp_pc;
            w_n_ctrl[w_widx]  = w_d_ctrl;
            w_n_info[w_widx]  = disp_info;
            for (int k = 0; k < IQ_NUM_OPS; k++) begin
                w_n_tag[w_widx][k] = w_d_tag[k];
                if (!w_d_rdy[k] && cdb_valid && (w_d_tag[k] == cdb_tag)) begin
                    w_n_rdy[w_widx][k] = 1'b1;
                    w_n_val[w_widx][k] = cdb_data;
                end else begin
                    w_n_rdy[w_widx][k] = w_d_rdy[k];
                    w_n_val[w_widx][k] = w_d_val[k];
                end
            end
        end
    end

    // Occupancy and valid bits; reset and flush both empty the queue
    always_ff @(posedge CLK) begin
        if (!RESET || flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_valid <= w_n_valid;
            r_count <= r_count + CNT_W'(w_disp) - CNT_W'(w_issue);
        end
    end

    // Entry payload; contents are don't-care wherever the valid bit is clear
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            r_instr[i] <= w_n_instr[i];
            r_pc[i]    <= w_n_pc[i];
            r_ctrl[i]  <= w_n_ctrl[i];
            r_info[i]  <= w_n_info[i];
            r_rdy[i]   <= w_n_rdy[i];
            r_val[i]   <= w_n_val[i];
            r_tag[i]   <= w_n_tag[i];
        end
    end

    // EXE operand registers: load oldest ready, insert a bubble, or hold under stall
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            iss_valid    <= 1'b0;
            iss_instr    <= '0;
            iss_pc       <= '0;
            iss_opa      <= '0;
            iss_opb      <= '0;
            iss_memwdata <= '0;
            iss_alu_ctrl <= '0;
            iss_shamt    <= '0;
            iss_wreg     <= '0;
            iss_regwrite <= 1'b0;
            iss_memread  <= 1'b0;
            iss_memwrite <= 1'b0;
            iss_info     <= '0;
        end else if (flush) begin
            iss_valid <= 1'b0;
            iss_pc    <= '0;
        end else if (!stall) begin
            if (w_found) begin
                iss_valid    <= 1'b1;
                iss_instr    <= r_instr[w_sel];
                iss_pc       <= r_pc[w_sel];
                iss_opa      <= r_val[w_sel][OP_A];
                iss_opb      <= r_val[w_sel][OP_B];
                iss_memwdata <= r_val[w_sel][OP_C];
                iss_alu_ctrl <= r_ctrl[w_sel].alu_ctrl;
                iss_shamt    <= r_ctrl[w_sel].shamt;
                iss_wreg     <= r_ctrl[w_sel].wreg;
                iss_regwrite <= r_ctrl[w_sel].regwrite;
                iss_memread  <= r_ctrl[w_sel].memread;
                iss_memwrite <= r_ctrl[w_sel].memwrite;
                iss_info     <= r_info[w_sel];
            end else begin
                iss_valid    <= 1'b0;
                iss_instr    <= '0;
                iss_pc       <= '0;
                iss_alu_ctrl <= '0;
                iss_shamt    <= '0;
                iss_wreg     <= '0;
                iss_regwrite <= 1'b0;
                iss_memread  <= 1'b0;
                iss_memwrite <= 1'b0;
            end
        end
    end

endmodule
